// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared state codes and handshake levels for the iterative divider
package div_unit_pkg;
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
endpackage

// File: rtl/div_unit.sv
// div_unit: 32-step restoring divider, signed/unsigned, result = {remainder, quotient}
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);
  div_state_t          state;
  logic [5:0]          cnt;
  logic [2*WIDTH:0]    work;
  logic [WIDTH-1:0]    divisor;
  logic                neg_q;
  logic                neg_r;
  logic [WIDTH-1:0]    mag1;
  logic [WIDTH-1:0]    mag2;
  logic [WIDTH:0]      diff;
  logic [2*WIDTH:0]    stepped;
  logic [2*WIDTH:0]    finalized;
  logic                last;
  always_comb begin
    mag1      = signed_div_i && opdata1_i[WIDTH-1] ? -opdata1_i : opdata1_i;
    mag2      = signed_div_i && opdata2_i[WIDTH-1] ? -opdata2_i : opdata2_i;
    diff      = {1'b0, work[2*WIDTH-1:WIDTH]} - {1'b0, divisor};
    stepped   = diff[WIDTH] ? {work[2*WIDTH-1:0], 1'b0} : {diff[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
    last      = cnt == 6'd31;
    // the final step folds in the sign fix-up so the result is ready one edge later
    finalized = {neg_r ? -stepped[2*WIDTH:WIDTH+1] : stepped[2*WIDTH:WIDTH+1], stepped[WIDTH],
                 neg_q ? -stepped[WIDTH-1:0] : stepped[WIDTH-1:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          ready_o  <= DIV_RESULT_NOT_READY;
          result_o <= '0;
          if (start_i == DIV_START && !annul_i) begin
            state   <= opdata2_i == '0 ? DIV_BY_ZERO : DIV_ON;
            cnt     <= '0;
            work    <= {{WIDTH{1'b0}}, mag1, 1'b0};
            divisor <= mag2;
            neg_q   <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r   <= signed_div_i && opdata1_i[WIDTH-1];
          end
        end
        DIV_BY_ZERO: begin
          work  <= '0;
          state <= annul_i ? DIV_FREE : DIV_END;
        end
        DIV_ON: begin
          if (annul_i) begin
            state <= DIV_FREE;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + 6'd1;
            work  <= last ? finalized : stepped;
            state <= last ? DIV_END : DIV_ON;
          end
        end
        DIV_END: begin
          result_o <= {work[2*WIDTH:WIDTH+1], work[WIDTH-1:0]};
          ready_o  <= DIV_RESULT_READY;
          if (start_i == DIV_STOP) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
            result_o <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous, active-high (`RstEnable).
REQ-004 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
REQ-005 opdata1_i  input  32  dividend; sampled with start_i.
REQ-006 opdata2_i  input  32  divisor; sampled with start_i.
REQ-007 start_i  input  1  `DivStart requests a division; held by the EX stage until ready_o.
REQ-008 annul_i  input  1  1 cancels the operation in progress (flush/exception).
REQ-009 result_o  output  64  {remainder[63:32], quotient[31:0]}.
REQ-010 ready_o  output  1  `DivResultReady when result_o is valid.

Function
REQ-011 The FSM SHALL have four states: DivFree, DivByZero, DivOn, DivEnd, encoded as 2-bit `define constants.
REQ-012 In DivFree with start_i=1 and annul_i=0, the block SHALL capture the operands: divisor==0 goes to DivByZero; otherwise goes to DivOn with cnt=0.
REQ-013 The capture cycle SHALL convert negative operands to their two's-complement magnitude when signed_div_i=1.
REQ-014 DivByZero SHALL clear the working register and go to DivEnd on the next edge.
REQ-015 DivOn SHALL perform one restoring step per cycle on a 65-bit working register {partial remainder, dividend, quotient bit}.
REQ-016 Each step: if partial remainder minus divisor is negative, shift left inserting 0; else store the difference and shift left inserting 1.
REQ-017 The 6-bit counter cnt SHALL increment once per step; after 32 steps (cnt==32) the FSM goes to DivEnd.
REQ-018 On leaving DivOn, a signed operation SHALL negate the quotient if the operand signs differ and negate the remainder if the dividend is negative.
REQ-019 In DivEnd, result_o SHALL be registered from the working register and ready_o set to 1.
REQ-020 The FSM SHALL stay in DivEnd while start_i=1; on start_i=0 it returns to DivFree with ready_o=0 and result_o=0.
REQ-021 Latency: counting the start-sampling edge as 1, ready_o SHALL rise after edge 34 for a normal division and after edge 3 for divide-by-zero.
REQ-022 annul_i=1 in DivOn or DivByZero SHALL return the FSM to DivFree next edge with ready_o=0 and no result.
REQ-023 annul_i=1 in DivFree SHALL block start; in DivEnd it has no effect.
REQ-024 A divide-by-zero result SHALL be 64'h0 for both signed and unsigned operation.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-026 Operand changes while busy SHALL be ignored; only the captured values are used.

Reset
REQ-027 While rst is asserted: state = DivFree, cnt=0, working register=0, result_o=64'h0, ready_o=0.
REQ-028 Reset mid-operation SHALL abandon the division with no ready_o pulse; the next start SHALL work normally.

Structure
REQ-029 The state codes, `DivStart/`DivStop and `DivResultReady/`DivResultNotReady SHALL live in the shared defines.v.
REQ-030 div_unit is a leaf module instantiated beside the EX stage.
REQ-031 While ready_o=0 and start_i=1, the EX stage SHALL assert its stall request; stall propagates via the control module to the ex/mem register.

Verification
REQ-032 Unsigned 100/7 -> after 34 edges ready_o=1, result_o={32'd2, 32'd14}; ready held until start_i=0.
REQ-033 Signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-034 Divisor 0, dividend 0x12345678 -> ready_o=1 after 3 edges, result_o=64'h0.
REQ-035 annul_i pulsed at step 10 of 0xFFFFFFFF/3 -> no ready_o; a new start 9/3 yields {0, 3} after 34 edges.
REQ-036 rst asserted at step 20 -> all outputs 0 next edge; signed 0x80000000/0xFFFFFFFF then yields {0, 0x80000000}.
